// File: rtl/sdm_tx_fifo_if.sv
// sdm_tx_fifo_if: host/bit-clock bundle for the sigma-delta transmitter.
//   en, clear, push, wdata : host controls and sample write port
//   fclk                   : asynchronous bit clock (one tick per rising edge)
//   full, empty, level     : FIFO status
//   tx, frame, busy        : modulated bitstream, frame-start strobe, running flag
//   underrun, overflow     : sticky error flags
// master = host side (drives controls), slave = transmitter side.
`timescale 1ns/1ps
interface sdm_tx_fifo_if #(
    parameter int W          = 4,
    parameter int DEPTH_LOG2 = 2
);
    logic                  en;
    logic                  clear;
    logic                  push;
    logic [W-1:0]          wdata;
    logic                  fclk;
    logic                  full;
    logic                  empty;
    logic [DEPTH_LOG2:0]   level;
    logic                  tx;
    logic                  frame;
    logic                  busy;
    logic                  underrun;
    logic                  overflow;

    modport master (
        output en, clear, push, wdata, fclk,
        input  full, empty, level, tx, frame, busy, underrun, overflow
    );

    modport slave (
        input  en, clear, push, wdata, fclk,
        output full, empty, level, tx, frame, busy, underrun, overflow
    );
endinterface

// File: rtl/sdm_tx_fifo.sv
// sdm_tx_fifo: first-order sigma-delta pulse-density transmitter with a
// sample FIFO in front of it.
//   clk, rstn : system clock, asynchronous active-low reset
//   bus       : sdm_tx_fifo_if.slave (host controls, FIFO status, bitstream)
// Each signed W-bit sample becomes a frame of 2^LOG2_OSR bits whose ones
// count is u * 2^(LOG2_OSR-W), u being the sample in offset-binary form.
`timescale 1ns/1ps
module sdm_tx_fifo #(
    parameter int W             = 4,
    parameter int LOG2_OSR      = 4,
    parameter int DEPTH_LOG2    = 2,
    parameter int UNDERRUN_HOLD = 0
) (
    input logic          clk,
    input logic          rstn,
    sdm_tx_fifo_if.slave bus
);

    localparam int                    D        = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   LVL_FULL = (DEPTH_LOG2 + 1)'(D);
    localparam logic [LOG2_OSR-1:0]   CNT_LAST = '1;
    localparam logic [W-1:0]          MID      = {1'b1, {(W-1){1'b0}}};

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;

    // ------------------------------------------------------------------
    // fclk synchronizer and rising-edge tick
    // ------------------------------------------------------------------
    logic [2:0] fsync;
    logic       tick;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours (the shift works).
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) fsync <= '0;
        else       fsync <= {fsync[1:0], bus.fclk};
    end

    assign tick = fsync[1] & ~fsync[2];

    // ------------------------------------------------------------------
    // Sample FIFO
    // ------------------------------------------------------------------
    logic [W-1:0]          mem [D];
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic                  fifo_empty, fifo_full;
    logic                  pop, push_ok;
    logic                  overflow_q;
    logic [W-1:0]          head_u;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == LVL_FULL);
    // A push into a full FIFO still fits when the head leaves this cycle.
    assign push_ok    = bus.push & (~fifo_full | pop);
    // Flipping the sign bit turns two's complement into offset binary.
    assign head_u     = mem[rd_ptr] ^ MID;

    // NOTE: the storage array has no reset; the pointers and count alone
    // define which entries are valid, so stale contents are never read.
    always_ff @(posedge clk) begin
        if (push_ok && !bus.clear) mem[wr_ptr] <= bus.wdata;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_q <= 1'b0;
        end else if (bus.clear) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (bus.push && !push_ok) overflow_q <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Frame sequencer and first-order modulator
    // ------------------------------------------------------------------
    logic [1:0]          state;
    logic [W-1:0]        u_reg;
    logic [W-1:0]        acc;
    logic [LOG2_OSR-1:0] cnt;
    logic                tx_q, frame_q, underrun_q;
    logic [W:0]          sum;
    logic                frame_end;

    assign sum       = {1'b0, acc} + {1'b0, u_reg};
    assign frame_end = (state == S_RUN) & tick & (cnt == CNT_LAST);
    // The sequencer is the only reader; it pops on LOAD and at a frame
    // boundary that continues with queued data. Clear suppresses both.
    assign pop = ~bus.clear &
                 ((state == S_LOAD) | (frame_end & bus.en & ~fifo_empty));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= S_IDLE;
            u_reg      <= MID;
            acc        <= '0;
            cnt        <= '0;
            tx_q       <= 1'b0;
            frame_q    <= 1'b0;
            underrun_q <= 1'b0;
        end else if (bus.clear) begin
            state      <= S_IDLE;
            acc        <= '0;
            cnt        <= '0;
            tx_q       <= 1'b0;
            frame_q    <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            frame_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    tx_q <= 1'b0;
                    acc  <= '0;
                    cnt  <= '0;
                    if (bus.en && !fifo_empty) state <= S_LOAD;
                end
                S_LOAD: begin
                    u_reg <= head_u;
                    state <= S_RUN;
                end
                S_RUN: begin
                    if (tick) begin
                        // Carry out of acc + u is the output bit; the residue
                        // in acc carries into the next frame.
                        acc     <= sum[W-1:0];
                        tx_q    <= sum[W];
                        frame_q <= (cnt == '0);
                        cnt     <= cnt + 1'b1;
                        if (cnt == CNT_LAST) begin
                            if (!bus.en) begin
                                state <= S_IDLE;
                            end else if (!fifo_empty) begin
                                u_reg <= head_u;
                            end else begin
                                underrun_q <= 1'b1;
                                if (UNDERRUN_HOLD == 0) u_reg <= MID;
                            end
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.full     = fifo_full;
    assign bus.empty    = fifo_empty;
    assign bus.level    = count;
    assign bus.tx       = tx_q;
    assign bus.frame    = frame_q;
    assign bus.busy     = (state == S_RUN);
    assign bus.underrun = underrun_q;
    assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_sdm_tx_fifo.sv
// tb_sdm_tx_fifo: self-checking bench for sdm_tx_fifo. Three instances:
//   dut0 W=4 LOG2_OSR=4 mid-scale underrun, dut1 same with hold-last,
//   dut2 W=3 LOG2_OSR=5. fclk runs with an 8-clk period, so a bit is
//   sampled every 8 clk after the frame strobe. Expected ones per frame
//   come from u * 2^(LOG2_OSR-W) on a queue of accepted samples.
`timescale 1ns/1ps
module tb_sdm_tx_fifo;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    logic fclk = 1'b0;

    always #5 clk = ~clk;

    initial begin
        forever begin
            repeat (4) @(posedge clk);
            #2 fclk = ~fclk;
        end
    end

    sdm_tx_fifo_if #(.W(4), .DEPTH_LOG2(2)) if0 ();
    sdm_tx_fifo_if #(.W(4), .DEPTH_LOG2(2)) if1 ();
    sdm_tx_fifo_if #(.W(3), .DEPTH_LOG2(2)) if2 ();

    assign if0.fclk = fclk;
    assign if1.fclk = fclk;
    assign if2.fclk = fclk;

    sdm_tx_fifo #(.W(4), .LOG2_OSR(4), .DEPTH_LOG2(2), .UNDERRUN_HOLD(0))
        dut0 (.clk(clk), .rstn(rstn), .bus(if0.slave));
    sdm_tx_fifo #(.W(4), .LOG2_OSR(4), .DEPTH_LOG2(2), .UNDERRUN_HOLD(1))
        dut1 (.clk(clk), .rstn(rstn), .bus(if1.slave));
    sdm_tx_fifo #(.W(3), .LOG2_OSR(5), .DEPTH_LOG2(2), .UNDERRUN_HOLD(0))
        dut2 (.clk(clk), .rstn(rstn), .bus(if2.slave));

    int tests_run    = 0;
    int tests_failed = 0;
    int sel          = 0;

    logic mon_tx, mon_frame, mon_busy;

    always_comb begin
        mon_tx    = if0.tx;
        mon_frame = if0.frame;
        mon_busy  = if0.busy;
        case (sel)
            1: begin mon_tx = if1.tx; mon_frame = if1.frame; mon_busy = if1.busy; end
            2: begin mon_tx = if2.tx; mon_frame = if2.frame; mon_busy = if2.busy; end
            default: ;
        endcase
    end

    // Reference: ones per frame for signed sample d.
    function automatic int ref_ones(input int d, input int w, input int l);
        int u;
        u = d + (1 << (w - 1));
        return u << (l - w);
    endfunction

    task automatic set_en(input logic v);
        case (sel)
            0:       if0.en = v;
            1:       if1.en = v;
            default: if2.en = v;
        endcase
    endtask

    task automatic push_s(input int d);
        case (sel)
            0:       begin if0.push = 1'b1; if0.wdata = 4'(d); end
            1:       begin if1.push = 1'b1; if1.wdata = 4'(d); end
            default: begin if2.push = 1'b1; if2.wdata = 3'(d); end
        endcase
        @(negedge clk);
        if0.push = 1'b0;
        if1.push = 1'b0;
        if2.push = 1'b0;
    endtask

    task automatic pulse_clear0();
        if0.clear = 1'b1;
        @(negedge clk);
        if0.clear = 1'b0;
    endtask

    // Capture nbits of a frame. aligned=1: the strobe must arrive exactly
    // one bit period after the previous frame's last bit.
    task automatic collect(input int nbits, input bit aligned, input int drop_at,
                           output int ones, output logic [31:0] bits);
        int waited;
        bits = '0;
        ones = 0;
        if (aligned) begin
            repeat (8) @(negedge clk);
            tests_run++;
            if (mon_frame !== 1'b1) begin
                $display("FAIL frame_spacing: frame=%b, expected 1", mon_frame);
                tests_failed++;
            end
        end else begin
            waited = 0;
            while (mon_frame !== 1'b1 && waited < 3000) begin
                @(negedge clk);
                waited++;
            end
            tests_run++;
            if (mon_frame !== 1'b1) begin
                $display("FAIL frame_timeout: no frame strobe after %0d cycles", waited);
                tests_failed++;
            end
        end
        bits[0] = mon_tx;
        if (drop_at == 0) set_en(1'b0);
        @(negedge clk);
        tests_run++;
        if (mon_frame !== 1'b0) begin
            $display("FAIL frame_width: frame=%b one clk after strobe, expected 0", mon_frame);
            tests_failed++;
        end
        for (int i = 1; i < nbits; i++) begin
            repeat ((i == 1) ? 7 : 8) @(negedge clk);
            bits[i] = mon_tx;
            if (i == drop_at) set_en(1'b0);
        end
        for (int i = 0; i < nbits; i++) ones += int'(bits[i]);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (mon_busy === 1'b1 && n < 600) begin
            @(negedge clk);
            n++;
        end
        tests_run++;
        if (mon_busy !== 1'b0) begin
            $display("FAIL idle_timeout: busy=%b after %0d cycles, expected 0", mon_busy, n);
            tests_failed++;
        end
        @(negedge clk);
        tests_run++;
        if (mon_tx !== 1'b0) begin
            $display("FAIL idle_tx: tx=%b, expected 0", mon_tx);
            tests_failed++;
        end
    endtask

    task automatic test_reset();
        logic [6:0] st;
        #23;
        st = {if0.tx, if0.frame, if0.busy, if0.underrun, if0.overflow, if0.empty, if0.full};
        tests_run++;
        if (st !== 7'b0000010 || if0.level !== 3'd0) begin
            $display("FAIL reset_dut0: status=%b level=%0d, expected 0000010 level 0", st, if0.level);
            tests_failed++;
        end
        st = {if2.tx, if2.frame, if2.busy, if2.underrun, if2.overflow, if2.empty, if2.full};
        tests_run++;
        if (st !== 7'b0000010 || if2.level !== 3'd0) begin
            $display("FAIL reset_dut2: status=%b level=%0d, expected 0000010 level 0", st, if2.level);
            tests_failed++;
        end
        @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        int ones;
        logic [31:0] bits;
        int exp_ones [3];
        int smp [3];
        smp = '{-8, 0, 7};
        exp_ones = '{0, 8, 15};
        sel = 0;
        for (int i = 0; i < 3; i++) push_s(smp[i]);
        tests_run++;
        if (if0.level !== 3'd3) begin
            $display("FAIL basic_level: level=%0d, expected 3", if0.level);
            tests_failed++;
        end
        set_en(1'b1);
        for (int i = 0; i < 3; i++) begin
            collect(16, i > 0, -1, ones, bits);
            tests_run++;
            if (ones !== exp_ones[i] || ones !== ref_ones(smp[i], 4, 4)) begin
                $display("FAIL basic_ones[%0d]: ones=%0d, expected %0d", i, ones, exp_ones[i]);
                tests_failed++;
            end
        end
        collect(16, 1'b1, 8, ones, bits);
        tests_run++;
        if (bits[15:0] !== 16'hAAAA) begin
            $display("FAIL basic_midscale: bits=%h, expected aaaa", bits[15:0]);
            tests_failed++;
        end
        tests_run++;
        if (if0.underrun !== 1'b1) begin
            $display("FAIL basic_underrun: underrun=%b, expected 1", if0.underrun);
            tests_failed++;
        end
        wait_idle();
    endtask

    task automatic test_fifo_random();
        int q [$];
        int k, d, ones;
        logic [31:0] bits;
        sel = 0;
        for (int it = 0; it < 3; it++) begin
            pulse_clear0();
            q.delete();
            k = (it == 0) ? 6 : int'($urandom_range(1, 6));
            for (int j = 0; j < k; j++) begin
                d = int'($urandom_range(0, 15)) - 8;
                push_s(d);
                if (q.size() < 4) q.push_back(d);
            end
            tests_run++;
            if (if0.level !== 3'(q.size()) || if0.full !== (k >= 4) ||
                if0.overflow !== (k > 4) || if0.empty !== 1'b0) begin
                $display("FAIL fifo_status[%0d]: level=%0d full=%b ovf=%b empty=%b, expected %0d %b %b 0",
                         it, if0.level, if0.full, if0.overflow, if0.empty,
                         q.size(), (k >= 4), (k > 4));
                tests_failed++;
            end
            set_en(1'b1);
            for (int j = 0; j < q.size(); j++) begin
                collect(16, j > 0, -1, ones, bits);
                tests_run++;
                if (ones !== ref_ones(q[j], 4, 4)) begin
                    $display("FAIL fifo_frame[%0d][%0d]: ones=%0d, expected %0d (sample %0d)",
                             it, j, ones, ref_ones(q[j], 4, 4), q[j]);
                    tests_failed++;
                end
            end
            collect(16, 1'b1, 8, ones, bits);
            tests_run++;
            if (ones !== 8 || if0.underrun !== 1'b1) begin
                $display("FAIL fifo_underrun[%0d]: ones=%0d underrun=%b, expected 8 1",
                         it, ones, if0.underrun);
                tests_failed++;
            end
            wait_idle();
        end
    endtask

    task automatic test_graceful_stop();
        int ones;
        logic [31:0] bits;
        sel = 0;
        push_s(5);
        push_s(-3);
        set_en(1'b1);
        collect(16, 1'b0, 5, ones, bits);
        tests_run++;
        if (ones !== ref_ones(5, 4, 4)) begin
            $display("FAIL stop_ones: ones=%0d, expected %0d", ones, ref_ones(5, 4, 4));
            tests_failed++;
        end
        @(negedge clk);
        tests_run++;
        if (if0.busy !== 1'b0 || if0.tx !== 1'b0 || if0.level !== 3'd1) begin
            $display("FAIL stop_idle: busy=%b tx=%b level=%0d, expected 0 0 1",
                     if0.busy, if0.tx, if0.level);
            tests_failed++;
        end
        set_en(1'b1);
        collect(16, 1'b0, 8, ones, bits);
        tests_run++;
        if (ones !== ref_ones(-3, 4, 4)) begin
            $display("FAIL restart_ones: ones=%0d, expected %0d", ones, ref_ones(-3, 4, 4));
            tests_failed++;
        end
        wait_idle();
    endtask

    task automatic test_clear();
        int ones;
        logic [31:0] bits;
        sel = 0;
        for (int i = 0; i < 6; i++) push_s(i - 3);
        tests_run++;
        if (if0.overflow !== 1'b1 || if0.underrun !== 1'b1 || if0.full !== 1'b1) begin
            $display("FAIL preclear_flags: ovf=%b und=%b full=%b, expected 1 1 1",
                     if0.overflow, if0.underrun, if0.full);
            tests_failed++;
        end
        set_en(1'b1);
        collect(10, 1'b0, -1, ones, bits);
        if0.clear = 1'b1;
        if0.push  = 1'b1;
        if0.wdata = 4'd5;
        @(negedge clk);
        if0.clear = 1'b0;
        if0.push  = 1'b0;
        tests_run++;
        if (if0.tx !== 1'b0 || if0.empty !== 1'b1 || if0.level !== 3'd0 ||
            if0.underrun !== 1'b0 || if0.overflow !== 1'b0 || if0.busy !== 1'b0) begin
            $display("FAIL clear_state: tx=%b empty=%b level=%0d und=%b ovf=%b busy=%b, expected 0 1 0 0 0 0",
                     if0.tx, if0.empty, if0.level, if0.underrun, if0.overflow, if0.busy);
            tests_failed++;
        end
        repeat (20) @(negedge clk);
        tests_run++;
        if (if0.busy !== 1'b0 || if0.level !== 3'd0) begin
            $display("FAIL clear_stays_idle: busy=%b level=%0d, expected 0 0", if0.busy, if0.level);
            tests_failed++;
        end
        set_en(1'b0);
    endtask

    task automatic test_hold();
        int ones;
        logic [31:0] bits;
        sel = 1;
        push_s(3);
        set_en(1'b1);
        for (int i = 0; i < 3; i++) begin
            collect(16, i > 0, -1, ones, bits);
            tests_run++;
            if (ones !== ref_ones(3, 4, 4)) begin
                $display("FAIL hold_ones[%0d]: ones=%0d, expected %0d", i, ones, ref_ones(3, 4, 4));
                tests_failed++;
            end
        end
        tests_run++;
        if (if1.underrun !== 1'b1 || if1.busy !== 1'b1) begin
            $display("FAIL hold_flags: underrun=%b busy=%b, expected 1 1", if1.underrun, if1.busy);
            tests_failed++;
        end
        set_en(1'b0);
        wait_idle();
    endtask

    task automatic test_w3();
        int ones;
        logic [31:0] bits;
        sel = 2;
        for (int i = 0; i < 4; i++) push_s(1);
        set_en(1'b1);
        for (int i = 0; i < 4; i++) begin
            collect(32, i > 0, -1, ones, bits);
            tests_run++;
            if (ones !== ref_ones(1, 3, 5)) begin
                $display("FAIL w3_ones[%0d]: ones=%0d, expected %0d", i, ones, ref_ones(1, 3, 5));
                tests_failed++;
            end
        end
        set_en(1'b0);
        wait_idle();
    endtask

    task automatic test_reset_mid_frame();
        int ones;
        logic [31:0] bits;
        sel = 0;
        push_s(2);
        push_s(-1);
        set_en(1'b1);
        collect(6, 1'b0, -1, ones, bits);
        #3 rstn = 1'b0;
        #1;
        tests_run++;
        if (if0.busy !== 1'b0 || if0.tx !== 1'b0 || if0.frame !== 1'b0 ||
            if0.level !== 3'd0 || if0.empty !== 1'b1) begin
            $display("FAIL async_reset: busy=%b tx=%b frame=%b level=%0d empty=%b, expected 0 0 0 0 1",
                     if0.busy, if0.tx, if0.frame, if0.level, if0.empty);
            tests_failed++;
        end
        @(negedge clk);
        rstn = 1'b1;
        repeat (40) @(negedge clk);
        tests_run++;
        if (if0.busy !== 1'b0 || if0.tx !== 1'b0) begin
            $display("FAIL reset_no_resume: busy=%b tx=%b, expected 0 0", if0.busy, if0.tx);
            tests_failed++;
        end
        set_en(1'b0);
    endtask

    initial begin
        if0.en = 1'b0; if0.clear = 1'b0; if0.push = 1'b0; if0.wdata = '0;
        if1.en = 1'b0; if1.clear = 1'b0; if1.push = 1'b0; if1.wdata = '0;
        if2.en = 1'b0; if2.clear = 1'b0; if2.push = 1'b0; if2.wdata = '0;
        test_reset();
        test_basic();
        test_fifo_random();
        test_graceful_stop();
        test_clear();
        test_hold();
        test_w3();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
